// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the EX-stage multiply/divide scheduler: opcodes, states, latencies.
package muldiv_sched_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_READ  = 3'd7;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_busy_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// EX-stage md operation request plus HI/LO and stall outputs of the scheduler.
interface muldiv_sched_if;

    logic        E_start;
    logic [2:0]  E_mdop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_rd_hi;
    logic        D_md_use;
    logic        E_busy;
    logic        E_start_busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_md_out;

    modport master (
        output E_start, E_mdop, E_A, E_B, E_rd_hi, D_md_use,
        input  E_busy, E_start_busy, md_stall, HI, LO, E_md_out
    );

    modport slave (
        input  E_start, E_mdop, E_A, E_B, E_rd_hi, D_md_use,
        output E_busy, E_start_busy, md_stall, HI, LO, E_md_out
    );

endinterface

// File: rtl/muldiv_calc.sv
// Combinational 64-bit product / quotient / remainder for mult, multu, div and divu.
module muldiv_calc
    import muldiv_sched_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic               b_zero;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    // One extra bit so that -2^31 / -1 does not overflow the signed divide.
    logic signed [32:0] dvd_s;
    logic signed [32:0] dvs_s;
    logic signed [32:0] quo_s;
    logic signed [32:0] rem_s;
    logic        [31:0] dvs_u;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               unused_msb;

    always_comb begin
        b_zero     = (b_i == 32'd0);
        div_zero_o = b_zero && is_div_op(op_i);

        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        dvd_s = $signed({a_i[31], a_i});
        dvs_s = b_zero ? 33'sd1 : $signed({b_i[31], b_i});
        quo_s = dvd_s / dvs_s;
        rem_s = dvd_s % dvs_s;

        dvs_u = b_zero ? 32'd1 : b_i;
        quo_u = a_i / dvs_u;
        rem_u = a_i % dvs_u;

        hi_o = 32'd0;
        lo_o = 32'd0;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prod_s;
            MD_MULTU: {hi_o, lo_o} = prod_u;
            MD_DIV: begin
                hi_o = rem_s[31:0];
                lo_o = quo_s[31:0];
            end
            MD_DIVU: begin
                hi_o = rem_u;
                lo_o = quo_u;
            end
            default: ;
        endcase
    end

    assign unused_msb = quo_s[32] ^ rem_s[32];

endmodule

// File: rtl/muldiv_sched.sv
// Multi-cycle mult/div sequencer owning HI/LO; raises md_stall while busy or starting.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_sched_if.slave md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_div_zero;

    muldiv_calc u_calc (
        .op_i       (md.E_mdop),
        .a_i        (md.E_A),
        .b_i        (md.E_B),
        .hi_o       (calc_hi),
        .lo_o       (calc_lo),
        .div_zero_o (calc_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        unique case (state_q)
            IDLE: begin
                if (md.E_start) begin
                    case (md.E_mdop)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            // Divide by zero re-commits the current registers.
                            pend_hi_d = calc_div_zero ? hi_q : calc_hi;
                            pend_lo_d = calc_div_zero ? lo_q : calc_lo;
                            cnt_d     = is_div_op(md.E_mdop) ? CntW'(DIV_CYCLES)
                                                             : CntW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        MD_MTHI:          hi_d = md.E_A;
                        MD_MTLO:          lo_d = md.E_A;
                        MD_NONE, MD_READ: ;
                        default:          ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.E_busy       = (state_q == BUSY);
    assign md.E_start_busy = md.E_start & is_busy_op(md.E_mdop);
    assign md.md_stall     = md.D_md_use & (md.E_busy | md.E_start_busy);
    assign md.HI           = hi_q;
    assign md.LO           = lo_q;
    assign md.E_md_out     = md.E_rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: directed cases from the plan plus randomized op streams.
module tb_muldiv_sched;

    localparam int NMULT = 5;
    localparam int NDIV  = 10;

    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_READ = 3'd7;

    localparam int K_RESET = 0, K_RESULT = 1, K_MTHI = 2, K_MTLO = 3;

    typedef struct {
        int          done;
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        keep;
    } exp_t;

    logic clk;
    logic reset;

    muldiv_sched_if bus ();

    muldiv_sched #(
        .MULT_CYCLES (NMULT),
        .DIV_CYCLES  (NDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          busy_from = -100;
    int          busy_until = -100;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t        sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: retires scoreboard entries when due, then checks every output against the model.
    initial begin
        exp_t        e;
        logic        exp_busy;
        logic        exp_sb;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            while (sb_q.size() > 0 && sb_q[0].done <= cyc) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_RESET: begin
                        m_hi = 32'd0;
                        m_lo = 32'd0;
                    end
                    K_RESULT: begin
                        if (!e.keep) begin
                            m_hi = e.hi;
                            m_lo = e.lo;
                        end
                    end
                    K_MTHI: m_hi = e.hi;
                    K_MTLO: m_lo = e.lo;
                    default: ;
                endcase
            end
            exp_busy = (cyc >= busy_from) && (cyc <= busy_until);
            exp_sb   = bus.E_start && (bus.E_mdop >= OP_MULT) && (bus.E_mdop <= OP_DIVU);
            check("HI", bus.HI, m_hi);
            check("LO", bus.LO, m_lo);
            check("E_busy", {31'd0, bus.E_busy}, {31'd0, exp_busy});
            check("E_start_busy", {31'd0, bus.E_start_busy}, {31'd0, exp_sb});
            check("md_stall", {31'd0, bus.md_stall},
                  {31'd0, bus.D_md_use && (exp_busy || exp_sb)});
            check("E_md_out", bus.E_md_out, bus.E_rd_hi ? m_hi : m_lo);
        end
    end

    // Drives one cycle of inputs and records the reference outcome if the op is accepted.
    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d, input logic rdhi);
        int          k;
        exp_t        e;
        longint      sa, sb;
        longint      r64;
        logic [63:0] u64;
        @(negedge clk);
        reset        = 1'b0;
        bus.E_start  = st;
        bus.E_mdop   = op;
        bus.E_A      = a;
        bus.E_B      = b;
        bus.D_md_use = use_d;
        bus.E_rd_hi  = rdhi;
        k = cyc + 1;
        if (st && k > busy_until + 1) begin
            e.done = k;
            e.keep = 1'b0;
            e.hi   = 32'd0;
            e.lo   = 32'd0;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                OP_MULT: begin
                    r64 = sa * sb;
                    u64 = r64;
                    {e.hi, e.lo} = u64;
                end
                OP_MULTU: begin
                    u64 = {32'd0, a} * {32'd0, b};
                    {e.hi, e.lo} = u64;
                end
                OP_DIV: begin
                    if (b == 32'd0) e.keep = 1'b1;
                    else begin
                        r64 = sa / sb;
                        u64 = r64;
                        e.lo = u64[31:0];
                        r64 = sa % sb;
                        u64 = r64;
                        e.hi = u64[31:0];
                    end
                end
                OP_DIVU: begin
                    if (b == 32'd0) e.keep = 1'b1;
                    else begin
                        e.lo = a / b;
                        e.hi = a % b;
                    end
                end
                default: ;
            endcase
            if (op >= OP_MULT && op <= OP_DIVU) begin
                e.kind     = K_RESULT;
                e.done     = k + ((op >= OP_DIV) ? NDIV : NMULT);
                busy_from  = k;
                busy_until = e.done - 1;
                sb_q.push_back(e);
            end else if (op == OP_MTHI) begin
                e.kind = K_MTHI;
                e.hi   = a;
                sb_q.push_back(e);
            end else if (op == OP_MTLO) begin
                e.kind = K_MTLO;
                e.lo   = a;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        int   k;
        exp_t e;
        @(negedge clk);
        reset       = 1'b1;
        bus.E_start = 1'b0;
        k = cyc + 1;
        sb_q.delete();
        e.done = k;
        e.kind = K_RESET;
        e.hi   = 32'd0;
        e.lo   = 32'd0;
        e.keep = 1'b0;
        sb_q.push_back(e);
        if (busy_until >= k) busy_until = k - 1;
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) issue(1'b0, OP_NONE, 32'd0, 32'd0, use_d, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        bus.E_start  = 1'b0;
        bus.E_mdop   = OP_NONE;
        bus.E_A      = 32'd0;
        bus.E_B      = 32'd0;
        bus.E_rd_hi  = 1'b0;
        bus.D_md_use = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // mthi then mtlo on consecutive edges, no busy period
        issue(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
        issue(1'b1, OP_MTLO, 32'h12345678, 32'd0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Signed vs unsigned multiply of -2 * 3, stall held through busy
        issue(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        idle(7, 1'b1);
        issue(1'b1, OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
        idle(7, 1'b0);

        // Signed divide -7/2, then divu by zero keeps 0x11/0x22
        issue(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        idle(12, 1'b1);
        issue(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        issue(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        issue(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b1, 1'b1);
        idle(12, 1'b0);

        // Reset during busy cycle 2 aborts the mult
        issue(1'b1, OP_MULT, 32'd1234, 32'd5678, 1'b1, 1'b0);
        idle(1, 1'b1);
        do_reset();
        idle(10, 1'b1);

        // Back-to-back mult then div, with illegal starts while busy
        issue(1'b1, OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        issue(1'b1, OP_MTHI, 32'hBAD0BAD0, 32'd0, 1'b0, 1'b1);
        issue(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0, 1'b0);
        idle(3, 1'b0);
        issue(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(1'b1, OP_MTLO, 32'hBAD1BAD1, 32'd0, 1'b1, 1'b0);
        idle(12, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                issue($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_operand(),
                      rnd_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        idle(NDIV + 3, 1'b0);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
